// File: rtl/countdown_sched.sv
// Round-robin scheduler that shares one external down counter among NREQ requesters.
// The winner's delay is loaded, counted down to zero, and then a one-cycle DONE is pulsed back.
module countdown_sched #(
   parameter int W    = 32,
   parameter int NREQ = 4,
   parameter int IW   = 2
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic [NREQ-1:0]   REQ,
   input  logic [NREQ*W-1:0] DLY,
   output logic [NREQ-1:0]   GNT,
   output logic [NREQ-1:0]   DONE,
   output logic              BUSY,
   output logic [W-1:0]      CNT_D,
   output logic              CNT_LD,
   output logic              CNT_EN,
   input  logic [W-1:0]      CNT_Q
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COUNT, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [IW-1:0] last_q, last_d;
   logic [IW-1:0] pick;
   logic          found;
   logic [W-1:0]  dly_a [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_dly
      assign dly_a[i] = DLY[i*W +: W];
   end

   // First pending request searching upward from the slot after the last winner.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!found && REQ[(int'(last_q) + k) % NREQ]) begin
            found = 1'b1;
            pick  = IW'((int'(last_q) + k) % NREQ);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         last_q  <= IW'(NREQ - 1);
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      last_d  = last_q;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               idx_d   = pick;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (!REQ[idx_q]) begin
               state_d = S_IDLE;
               last_d  = idx_q;
            end else begin
               state_d = S_COUNT;
            end
         end
         S_COUNT: begin
            if (!REQ[idx_q]) begin
               state_d = S_IDLE;
               last_d  = idx_q;
            end else if (CNT_Q == '0) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            last_d  = idx_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // An abort in COUNT suppresses the decrement in the same cycle.
   always_comb begin
      GNT    = '0;
      DONE   = '0;
      BUSY   = (state_q != S_IDLE);
      CNT_D  = '0;
      CNT_LD = 1'b0;
      CNT_EN = 1'b0;
      case (state_q)
         S_LOAD: begin
            CNT_LD     = 1'b1;
            CNT_D      = dly_a[idx_q];
            GNT[idx_q] = 1'b1;
         end
         S_COUNT: begin
            GNT[idx_q] = 1'b1;
            CNT_EN     = REQ[idx_q] && (CNT_Q != '0);
         end
         S_DONE: begin
            GNT[idx_q]  = 1'b1;
            DONE[idx_q] = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
